// File: rtl/serial_mag_compare_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_mag_compare_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit positions inside the registered result vector
    localparam int unsigned RES_LT = 0;
    localparam int unsigned RES_GT = 1;
    localparam int unsigned RES_EQ = 2;
    localparam int unsigned RES_W  = 3;

    // Counter width that stays legal when only one step exists
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare.
module cmp_chunk #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt_c,
    output logic             gt_c,
    output logic             eq_c
);

    assign lt_c = (a < b);
    assign gt_c = (a > b);
    assign eq_c = (a == b);

endmodule

// File: rtl/serial_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock, signed/unsigned.
// Optional feature macro: CMP_EARLY_EXIT_EN (finish on the first unequal chunk).
module serial_mag_compare
    import serial_mag_compare_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int unsigned NSTEP = WIDTH / CHUNK;
    localparam int unsigned SW    = cnt_width(NSTEP);
    localparam int unsigned LAST  = NSTEP - 1;

    generate
        if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("serial_mag_compare: CHUNK must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    state_t             state;
    state_t             state_nx;
    logic [SW-1:0]      step;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic               decided;
    logic               dec_lt;
    logic [RES_W-1:0]   res;
    logic [RES_W-1:0]   res_nx_c;
    logic               busy_q;
    logic               done_q;
    logic               accept_c;
    logic               finish_c;
    logic               early_c;
    logic               c_lt;
    logic               c_gt;
    logic               c_eq;
    logic [WIDTH-1:0]   sign_mask_c;

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
        .a    (sh_a[WIDTH-1 -: CHUNK]),
        .b    (sh_b[WIDTH-1 -: CHUNK]),
        .lt_c (c_lt),
        .gt_c (c_gt),
        .eq_c (c_eq)
    );

    // Flipping the sign bit of both operands maps two's complement onto unsigned order
    assign sign_mask_c = {is_signed, {(WIDTH-1){1'b0}}};

`ifdef CMP_EARLY_EXIT_EN
    assign early_c = !decided && !c_eq;
`else
    assign early_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        finish_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    accept_c = 1'b1;
                end
            end
            S_RUN: begin
                if (step == SW'(LAST) || early_c) begin
                    state_nx = S_DONE;
                    finish_c = 1'b1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nx = S_RUN;
                    accept_c = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A frozen decision wins over the chunk currently being compared
    always_comb begin
        res_nx_c         = '0;
        res_nx_c[RES_LT] = decided ? dec_lt  : c_lt;
        res_nx_c[RES_GT] = decided ? !dec_lt : c_gt;
        res_nx_c[RES_EQ] = !decided && c_eq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step    <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            decided <= 1'b0;
            dec_lt  <= 1'b0;
            res     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (accept_c) begin
                sh_a    <= a ^ sign_mask_c;
                sh_b    <= b ^ sign_mask_c;
                step    <= '0;
                decided <= 1'b0;
                dec_lt  <= 1'b0;
            end else if (state == S_RUN) begin
                sh_a <= sh_a << CHUNK;
                sh_b <= sh_b << CHUNK;
                step <= step + SW'(1);
                if (!decided && !c_eq) begin
                    decided <= 1'b1;
                    dec_lt  <= c_lt;
                end
            end
            if (finish_c) begin
                res <= res_nx_c;
            end
            busy_q <= (state_nx == S_RUN);
            done_q <= (state_nx == S_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = res[RES_LT];
    assign gt   = res[RES_GT];
    assign eq   = res[RES_EQ];

endmodule

// File: tb/tb_serial_mag_compare.sv
// Randomized self-checking bench for serial_mag_compare against an arithmetic reference model.
module tb_serial_mag_compare;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 2;
    localparam int unsigned NSTEP = WIDTH / CHUNK;
    localparam int          TMO   = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             is_signed = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_mag_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {eq,gt,lt} straight from signed/unsigned arithmetic
    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                           input logic rs);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic l;
        logic g;
        sa = ra;
        sb = rb;
        l  = rs ? (sa < sb) : (ra < rb);
        g  = rs ? (sa > sb) : (ra > rb);
        return {(ra == rb), g, l};
    endfunction

    // Cycles from the accepting edge to done
    function automatic int ref_lat(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb);
        int top;
        logic [WIDTH-1:0] x;
        x = ra ^ rb;
        if (x == '0) return NSTEP;
        top = 0;
        for (int i = 0; i < WIDTH; i++) if (x[i]) top = i;
`ifdef CMP_EARLY_EXIT_EN
        return (WIDTH - 1 - top) / CHUNK + 1;
`else
        return (top >= 0) ? NSTEP : 0;
`endif
    endfunction

    task automatic run_job(input string tag, input logic [WIDTH-1:0] ja, input logic [WIDTH-1:0] jb,
                           input logic js, input bit poke);
        logic [2:0] exp;
        logic [2:0] prev;
        int         lat;
        int         cyc;
        bit         held_ok;
        exp     = ref_res(ja, jb, js);
        lat     = ref_lat(ja, jb);
        prev    = {eq, gt, lt};
        held_ok = 1'b1;
        @(negedge clk);
        a = ja; b = jb; is_signed = js; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy_after_start"}, {31'd0, busy}, 32'd1);
        check({tag, ":done_low_after_start"}, {31'd0, done}, 32'd0);
        cyc = 1;
        while (!done && cyc < TMO) begin
            if ({eq, gt, lt} !== prev) held_ok = 1'b0;
            if (poke && cyc == 1 && lat > 2) begin
                start = 1'b1; a = ~ja; b = ~jb; is_signed = ~js;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (!done) cyc++;
        end
        check({tag, ":prev_result_held"}, {31'd0, held_ok}, 32'd1);
        check({tag, ":latency"}, 32'(cyc), 32'(lat));
        check({tag, ":result"}, {29'd0, eq, gt, lt}, {29'd0, exp});
        check({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               mode;
        bit               no_done;

        #12;
        check("reset_outputs", {27'd0, busy, done, lt, gt, eq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("idle_outputs", {27'd0, busy, done, lt, gt, eq}, 32'd0);

        run_job("t1_lt",       16'h1234, 16'h1235, 1'b0, 1'b0);
        idle(2);
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        run_job("t2_signed",   16'hFFFF, 16'h0001, 1'b1, 1'b0);
        run_job("t2_unsigned", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_job("t3_eq",       16'hABCD, 16'hABCD, 1'b0, 1'b0);
        run_job("t4_msb",      16'h8000, 16'h0000, 1'b0, 1'b0);
        run_job("t4_signed",   16'h8000, 16'h0000, 1'b1, 1'b0);

        // Reset in the middle of a job
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_reset_mid_run", {27'd0, busy, done, lt, gt, eq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) no_done = 1'b0;
        end
        check("t5_no_done_after_abort", {31'd0, no_done}, 32'd1);
        run_job("t5_after_reset", 16'h0F00, 16'h0E00, 1'b0, 1'b0);

        // Start pulsed during RUN, then back-to-back jobs from DONE
        run_job("t6_poke", 16'h1234, 16'h1235, 1'b0, 1'b1);
        run_job("t6_b2b_a", 16'h7000, 16'h7001, 1'b1, 1'b0);
        run_job("t6_b2b_b", 16'h0002, 16'h0001, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 3);
            ra   = WIDTH'($urandom);
            case (mode)
                0: rb = ra;
                1: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            run_job($sformatf("rnd%0d", n), ra, rb, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
        end

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
